// File: rtl/amba3_axi_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : amba3_axi_wr_arbiter
// Brief    : Round-robin AXI3 write-path arbiter (AW/W/B) for NUM_MST requesters.
// Revision : 1.0 - initial release
// ============================================================================
module amba3_axi_wr_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int TXID_SIZE  = 4,
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int MIDX      = $clog2(NUM_MST),
  localparam int STRB_SIZE = DATA_SIZE / 8,
  localparam int CTRL_SIZE = ADDR_SIZE + 18,
  localparam int IDW       = TXID_SIZE + MIDX
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_MST*TXID_SIZE-1:0]   s_awid,
  input  logic [NUM_MST*CTRL_SIZE-1:0]   s_awctrl,
  input  logic [NUM_MST-1:0]             s_awvalid,
  output logic [NUM_MST-1:0]             s_awready,
  input  logic [NUM_MST*DATA_SIZE-1:0]   s_wdata,
  input  logic [NUM_MST*STRB_SIZE-1:0]   s_wstrb,
  input  logic [NUM_MST-1:0]             s_wlast,
  input  logic [NUM_MST-1:0]             s_wvalid,
  output logic [NUM_MST-1:0]             s_wready,
  output logic [TXID_SIZE-1:0]           s_bid,
  output logic [1:0]                     s_bresp,
  output logic [NUM_MST-1:0]             s_bvalid,
  input  logic [NUM_MST-1:0]             s_bready,
  output logic [IDW-1:0]                 m_awid,
  output logic [CTRL_SIZE-1:0]           m_awctrl,
  output logic                           m_awvalid,
  input  logic                           m_awready,
  output logic [IDW-1:0]                 m_wid,
  output logic [DATA_SIZE-1:0]           m_wdata,
  output logic [STRB_SIZE-1:0]           m_wstrb,
  output logic                           m_wlast,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  input  logic [IDW-1:0]                 m_bid,
  input  logic [1:0]                     m_bresp,
  input  logic                           m_bvalid,
  output logic                           m_bready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [MIDX:0]  c_num_mst = (MIDX+1)'(NUM_MST);
  localparam logic [PTR_W:0] c_depth   = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [MIDX-1:0]        r_last_grant;
  logic [MIDX-1:0]        r_grant;
  logic [MIDX-1:0]        w_winner;
  logic [MIDX:0]          w_cand;
  logic                   w_found;
  logic                   w_aw_accept;
  logic [IDW-1:0]         r_m_awid;
  logic [CTRL_SIZE-1:0]   r_m_awctrl;

  logic [IDW-1:0]         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic [IDW-1:0]         w_head;
  logic [MIDX-1:0]        w_head_idx;

  logic [TXID_SIZE-1:0]   w_awid_arr  [NUM_MST];
  logic [CTRL_SIZE-1:0]   w_awctrl_arr[NUM_MST];
  logic [DATA_SIZE-1:0]   w_wdata_arr [NUM_MST];
  logic [STRB_SIZE-1:0]   w_wstrb_arr [NUM_MST];

  logic [MIDX-1:0]        w_bsel;
  logic                   w_bsel_ok;

  generate
    for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
      assign w_awid_arr[i]   = s_awid[i*TXID_SIZE +: TXID_SIZE];
      assign w_awctrl_arr[i] = s_awctrl[i*CTRL_SIZE +: CTRL_SIZE];
      assign w_wdata_arr[i]  = s_wdata[i*DATA_SIZE +: DATA_SIZE];
      assign w_wstrb_arr[i]  = s_wstrb[i*STRB_SIZE +: STRB_SIZE];
    end
  endgenerate

  // Descending scan so the requester closest after last_grant wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_last_grant} + (MIDX+1)'(k + 1);
      if (w_cand >= c_num_mst) begin
        w_cand = w_cand - c_num_mst;
      end
      if (s_awvalid[w_cand[MIDX-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[MIDX-1:0];
      end
    end
  end

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_aw_accept = !areset && (r_state == IDLE) && w_found && !w_full;

  always_comb begin
    w_state_nxt = r_state;
    s_awready   = '0;
    case (r_state)
      IDLE: begin
        if (w_aw_accept) begin
          s_awready[w_winner] = 1'b1;
          w_state_nxt         = HOLD;
        end
      end
      HOLD: begin
        if (m_awready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= IDLE;
      r_last_grant <= MIDX'(NUM_MST - 1);
      r_grant      <= '0;
      r_m_awid     <= '0;
      r_m_awctrl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_accept) begin
        r_grant    <= w_winner;
        r_m_awid   <= {w_winner, w_awid_arr[w_winner]};
        r_m_awctrl <= w_awctrl_arr[w_winner];
      end
      if ((r_state == HOLD) && m_awready) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign m_awvalid = (r_state == HOLD);
  assign m_awid    = r_m_awid;
  assign m_awctrl  = r_m_awctrl;

  // Ordering FIFO: one {index, id} entry per accepted AW, popped on wlast.
  always_ff @(posedge aclk) begin
    if (w_aw_accept) begin
      r_fifo[r_wr_ptr] <= {w_winner, w_awid_arr[w_winner]};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_aw_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_aw_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_head_idx = w_head[IDW-1:TXID_SIZE];

  always_comb begin
    m_wvalid = 1'b0;
    m_wid    = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    s_wready = '0;
    if (!w_empty) begin
      m_wvalid             = s_wvalid[w_head_idx];
      m_wid                = w_head;
      m_wdata              = w_wdata_arr[w_head_idx];
      m_wstrb              = w_wstrb_arr[w_head_idx];
      m_wlast              = s_wlast[w_head_idx];
      s_wready[w_head_idx] = m_wready;
    end
  end

  assign w_pop = !w_empty && m_wvalid && m_wready && m_wlast;

  // Responses carrying an out-of-range index are sunk so the slave never stalls.
  assign w_bsel    = m_bid[IDW-1:TXID_SIZE];
  assign w_bsel_ok = ({1'b0, w_bsel} < c_num_mst);
  assign m_bready  = w_bsel_ok ? s_bready[w_bsel] : 1'b1;
  assign s_bid     = m_bid[TXID_SIZE-1:0];
  assign s_bresp   = m_bresp;

  generate
    for (genvar i = 0; i < NUM_MST; i++) begin : g_bvalid
      assign s_bvalid[i] = m_bvalid && w_bsel_ok && (w_bsel == MIDX'(i));
    end
  endgenerate

endmodule
`default_nettype wire
